// File: rtl/uart_tx_fifo.sv
// Serial transmitter with an input FIFO, internal baud divider and run-time frame format.
// Frames are LSB-first on an idle-high line; queued words go out back-to-back.
module uart_tx_fifo #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic                       parity_en,
  input  logic                       parity_odd,
  input  logic                       two_stop,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(N);

  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] DATA_LAST = NW'(N - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  function automatic logic parity_bit(input logic [N-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic [N-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r, count_s;
  logic          push_s, pop_s;
  logic [N-1:0]  head_s;

  logic [2:0]    state_r, state_s;
  logic [BW-1:0] baud_r, baud_s;
  logic [NW-1:0] bit_r, bit_s, stop_last_s;
  logic [N-1:0]  shift_r, shift_s;
  logic          par_r, par_s;
  logic          cfg_pen_r, cfg_pen_s, cfg_two_r, cfg_two_s;
  logic          bit_end_s;
  logic          tx_r, tx_s, busy_r, tx_ready_r;

  assign push_s      = tx_valid && (count_r != FULL);
  assign head_s      = mem_r[rd_ptr_r];
  assign bit_end_s   = (baud_r == BAUD_LAST);
  assign stop_last_s = {{(NW-1){1'b0}}, cfg_two_r};

  assign tx         = tx_r;
  assign busy       = busy_r;
  assign tx_ready   = tx_ready_r;
  assign fifo_count = count_r;

  // FSM next state, baud/bit counters, shifter and per-frame config capture
  always_comb begin
    state_s   = state_r;
    bit_s     = bit_r;
    shift_s   = shift_r;
    par_s     = par_r;
    cfg_pen_s = cfg_pen_r;
    cfg_two_s = cfg_two_r;
    pop_s     = 1'b0;
    if (state_r == IDLE || bit_end_s) baud_s = '0;
    else                              baud_s = baud_r + BW'(1);

    case (state_r)
      IDLE: begin
        if (count_r != '0) begin
          pop_s   = 1'b1;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s = DATA;
          bit_s   = '0;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_s = {1'b0, shift_r[N-1:1]};
          if (bit_r == DATA_LAST) begin
            bit_s   = '0;
            state_s = cfg_pen_r ? PARITY : STOP;
          end else begin
            bit_s = bit_r + NW'(1);
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) state_s = STOP;
        else           state_s = PARITY;
      end
      STOP: begin
        if (bit_end_s) begin
          if (bit_r == stop_last_s) begin
            // Chain straight into the next start bit when more data is queued
            if (count_r != '0) begin
              pop_s   = 1'b1;
              state_s = START;
            end else begin
              state_s = IDLE;
            end
          end else begin
            bit_s = bit_r + NW'(1);
          end
        end else begin
          state_s = STOP;
        end
      end
      default: state_s = IDLE;
    endcase

    if (pop_s) begin
      shift_s   = head_s;
      par_s     = parity_bit(head_s, parity_odd);
      cfg_pen_s = parity_en;
      cfg_two_s = two_stop;
      baud_s    = '0;
      bit_s     = '0;
    end else begin
      par_s = par_r;
    end
  end

  // Line level for the state being entered, so tx is a pure register output
  always_comb begin
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      PARITY:  tx_s = par_s;
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  // FIFO occupancy next value
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CW'(1);
      2'b01:   count_s = count_r - CW'(1);
      default: count_s = count_r;
    endcase
  end

  // FSM, shifter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      baud_r    <= '0;
      bit_r     <= '0;
      shift_r   <= '0;
      par_r     <= 1'b0;
      cfg_pen_r <= 1'b0;
      cfg_two_r <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      baud_r    <= baud_s;
      bit_r     <= bit_s;
      shift_r   <= shift_s;
      par_r     <= par_s;
      cfg_pen_r <= cfg_pen_s;
      cfg_two_r <= cfg_two_s;
      tx_r      <= tx_s;
      busy_r    <= (state_s != IDLE);
    end
  end

  // FIFO pointers, count and ready flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      tx_ready_r <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r    <= count_s;
      tx_ready_r <= (count_s != FULL);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= tx_data;
  end

endmodule
